// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin two-port arbiter for a single-ported 32-bit data
//               memory, with atomic lock, range check and registered response.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH_WORDS  = 256,
    parameter int RESET_PRIO   = 0,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [1:0]  req_lock,
    input  logic [3:0]  req_be0,
    input  logic [3:0]  req_be1,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  resp_valid,
    output logic [1:0]  resp_err,
    output logic [31:0] resp_rdata0,
    output logic [31:0] resp_rdata1,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int                 c_cnt_w   = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(LOCK_TIMEOUT);
    localparam logic [31:0]        c_depth   = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_prio;
    logic [c_cnt_w-1:0] r_lock_cnt;
    logic [1:0]         r_resp_valid;
    logic [1:0]         r_resp_err;
    logic [31:0]        r_rdata0;
    logic [31:0]        r_rdata1;

    logic [1:0]  w_ready;
    logic        w_gnt;
    logic        w_port;
    logic        w_we;
    logic        w_lock;
    logic [3:0]  w_be;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_in_range;

    // Grant is forced off while reset is asserted so nothing reaches memory.
    always_comb begin
        w_ready = 2'b00;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (&req_valid) w_ready[r_prio] = 1'b1;
                    else            w_ready = req_valid;
                end
                S_LOCK0: w_ready[0] = req_valid[0];
                S_LOCK1: w_ready[1] = req_valid[1];
                default: w_ready = 2'b00;
            endcase
        end
    end

    assign w_gnt  = |w_ready;
    assign w_port = w_ready[1];

    always_comb begin
        w_we    = 1'b0;
        w_lock  = 1'b0;
        w_be    = 4'h0;
        w_addr  = 32'h0;
        w_wdata = 32'h0;
        if (w_ready[1]) begin
            w_we    = req_we[1];
            w_lock  = req_lock[1];
            w_be    = req_be1;
            w_addr  = req_addr1;
            w_wdata = req_wdata1;
        end else if (w_ready[0]) begin
            w_we    = req_we[0];
            w_lock  = req_lock[0];
            w_be    = req_be0;
            w_addr  = req_addr0;
            w_wdata = req_wdata0;
        end
    end

    assign w_in_range = ({2'b00, w_addr[31:2]} < c_depth);

    assign mem_we    = w_gnt & w_we & w_in_range;
    assign mem_be    = mem_we ? w_be : 4'h0;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'(RESET_PRIO);
            r_lock_cnt   <= '0;
            r_resp_valid <= 2'b00;
            r_resp_err   <= 2'b00;
            r_rdata0     <= 32'h0;
            r_rdata1     <= 32'h0;
        end else begin
            r_resp_valid <= w_ready;
            r_resp_err   <= w_ready & {2{~w_in_range}};
            // Read data is captured before the write lands, so writes return the old word.
            if (w_ready[0]) r_rdata0 <= w_in_range ? mem_rdata : 32'h0;
            if (w_ready[1]) r_rdata1 <= w_in_range ? mem_rdata : 32'h0;

            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_prio     <= ~w_port;
                        r_lock_cnt <= '0;
                        if (w_lock) r_state <= w_port ? S_LOCK1 : S_LOCK0;
                    end
                end
                S_LOCK0, S_LOCK1: begin
                    if (w_gnt) begin
                        r_lock_cnt <= '0;
                        if (!w_lock) r_state <= S_IDLE;
                    end else if (r_lock_cnt == c_timeout) begin
                        // Forced release hands priority to the port that was locked out.
                        r_state    <= S_IDLE;
                        r_lock_cnt <= '0;
                        r_prio     <= (r_state == S_LOCK0);
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata0 = r_rdata0;
    assign resp_rdata1 = r_rdata1;

endmodule
`default_nettype wire
